tx_frame_ctrl: RTL and testbench
================================

# tx_frame_ctrl

Transmit-side frame controller for the UART. It accepts one data byte per valid/ready handshake and builds the serial frame vector: start bit, 5–8 data bits LSB first, optional parity, one stop bit. It runs the baud-interval counter and drives the frame vector, bit index and per-bit shift strobe into the downstream TX shifter, which only selects `tx_frame[tx_index]` onto the line.

## Interface
Parameters:
- `UART_FRAME_SIZE`, default 4: width of `tx_index` and `uart_data_width`.
- `BAUD_DIV_W`, default 16: width of `baud_div`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; bits above the configured width are ignored.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  block can accept a byte.
- `uart_data_width`  in  UART_FRAME_SIZE  data bits per frame, legal 5..8.
- `baud_div`  in  BAUD_DIV_W  clocks per bit minus 1.
- `tx_frame`  out  11  frame vector; bit 0 is start; consumed by the shifter.
- `tx_index`  out  UART_FRAME_SIZE  bit currently on the line.
- `tx_shift`  out  1  one-cycle strobe at the end of each bit interval.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- States:
  - IDLE: `tx_ready`=1, `tx_busy`=0.
  - SHIFT: frame is being sent.
  - DONE: lasts one cycle, `tx_done`=1.
- Accept occurs when `tx_valid & tx_ready`. The block then:
  - samples `tx_data`, `uart_data_width` and `baud_div`;
  - builds `tx_frame`;
  - loads the baud counter with `baud_div`, sets `tx_index`=0 and enters SHIFT.
- Width W is `uart_data_width`, except values outside 5..8 are clamped to 8.
- Frame length N = W+2, or W+3 with parity. Frame vector layout:
  - `tx_frame[0]` = 0 (start bit).
  - `tx_frame[W:1]` = `tx_data[W-1:0]`.
  - Next bit is parity (when configured), then stop = 1.
  - All unused upper bits are 1.
- SHIFT behaviour:
  - The baud counter decrements every clock.
  - When it equals 0, `tx_shift`=1 for that cycle.
  - If `tx_index` < N-1: increment `tx_index` and reload the counter with the sampled `baud_div`.
  - If `tx_index` = N-1: go to DONE.
- DONE goes to IDLE. On that transition `tx_frame` is forced to all ones and `tx_index` to 0, so the line idles high.
- Mid-frame changes to `uart_data_width` and `baud_div` have no effect; only the values sampled at accept are used.
- `tx_valid` while busy is not accepted; the producer must hold its data until `tx_ready`.
- Reset values (asynchronous, any time, including mid-frame):
  - state IDLE;
  - `tx_frame` = 11'h7FF, `tx_index` = 0;
  - `tx_shift`, `tx_busy`, `tx_done` = 0; `tx_ready` = 1;
  - baud counter = 0.
  - The line returns high immediately through the shifter.

## Timing
- Accept at edge T: from T+1, `tx_index`=0, `tx_busy`=1, `tx_ready`=0.
- Each bit lasts exactly `baud_div`+1 cycles. `tx_shift` is high in the last cycle of each bit.
- `baud_div`=0 gives one cycle per bit, with `tx_shift` held high for all N cycles.
- `tx_done` is high in cycle T+1+N·(`baud_div`+1).
- `tx_ready` returns in the next cycle, so the minimum accept-to-accept spacing is N·(`baud_div`+1)+2 cycles.
- All outputs are registered except `tx_ready`, which is decoded from state. No combinational path from `tx_valid` to any output.

## Configuration
- `UART_MIKE_PARITY_EN` defined:
  - an even-parity bit (XOR of the W data bits) is inserted at `tx_frame[W+1]`;
  - stop moves to `tx_frame[W+2]`; N = W+3.
- Macro undefined: no parity bit, stop at `tx_frame[W+1]`, N = W+2. No parity logic is synthesized.

## Test plan
- `tx_data`=8'hA5, W=8, `baud_div`=3, no parity:
  - `tx_frame` = 11'h74A;
  - `tx_index` steps 0..9, 4 cycles each;
  - 10 `tx_shift` pulses;
  - `tx_done` at T+41.
- Same stimulus with `UART_MIKE_PARITY_EN`:
  - parity = 0, `tx_frame[9]`=0, `tx_frame[10]`=1;
  - N=11, `tx_done` at T+45.
- W=5, `tx_data`=8'hFF, `baud_div`=0:
  - `tx_frame[5:1]`=5'h1F, stop at bit 6;
  - `tx_shift` high 7 consecutive cycles;
  - `tx_done` at T+8.
- `uart_data_width`=3 and 12: both clamp to W=8 (frame length 10 without parity).
- `tx_valid` held high across frames: the second accept occurs exactly one cycle after `tx_done`. Changing `baud_div` mid-frame does not alter bit length.
- `rst` asserted at `tx_index`=4: same cycle `tx_frame`=11'h7FF, `tx_index`=0, `tx_busy`=0. After release, the next `tx_valid` is accepted in the first cycle.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_ctrl
// Description : UART transmit frame controller. Accepts one byte per
//               valid/ready handshake, builds the serial frame vector
//               (start, 5..8 data bits LSB first, optional even parity,
//               stop), runs the baud-interval counter and drives the bit
//               index and per-bit shift strobe to the downstream shifter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   UART_FRAME_SIZE  width of tx_index and uart_data_width (default 4)
//   BAUD_DIV_W       width of baud_div (default 16)
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   tx_data          byte to send (bits above the data width ignored)
//   tx_valid         producer offers tx_data
//   tx_ready         block can accept a byte (decoded from state)
//   uart_data_width  data bits per frame, legal 5..8, else treated as 8
//   baud_div         clocks per bit minus 1
//   tx_frame         frame vector, bit 0 = start bit
//   tx_index         bit currently on the line
//   tx_shift         one-cycle strobe in the last cycle of each bit
//   tx_busy          frame in progress
//   tx_done          one-cycle pulse after the stop bit completes
// Build option:
//   UART_MIKE_PARITY_EN  when defined, an even-parity bit follows the data
// ============================================================================
module tx_frame_ctrl #(
  parameter int UART_FRAME_SIZE = 4,
  parameter int BAUD_DIV_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [UART_FRAME_SIZE-1:0] uart_data_width,
  input  logic [BAUD_DIV_W-1:0]      baud_div,
  output logic [10:0]                tx_frame,
  output logic [UART_FRAME_SIZE-1:0] tx_index,
  output logic                       tx_shift,
  output logic                       tx_busy,
  output logic                       tx_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [10:0]                 r_frame, w_frame_nxt;
  logic [UART_FRAME_SIZE-1:0]  r_index, w_index_nxt;
  logic [UART_FRAME_SIZE-1:0]  r_last,  w_last_nxt;
  logic [BAUD_DIV_W-1:0]       r_cnt,   w_cnt_nxt;
  logic [BAUD_DIV_W-1:0]       r_div,   w_div_nxt;
  logic                        r_shift, w_shift_nxt;
  logic                        r_busy,  w_busy_nxt;
  logic                        r_done,  w_done_nxt;

  // Frame assembly from the live inputs; only used on the accept cycle.
  logic [3:0]                  w_width;
  logic [7:0]                  w_mask;
  logic [10:0]                 w_frame;
  logic [UART_FRAME_SIZE-1:0]  w_last;

  always_comb begin
    case (uart_data_width)
      UART_FRAME_SIZE'(5): w_width = 4'd5;
      UART_FRAME_SIZE'(6): w_width = 4'd6;
      UART_FRAME_SIZE'(7): w_width = 4'd7;
      default:             w_width = 4'd8;
    endcase
    w_mask  = 8'hFF >> (4'd8 - w_width);
    // Data bits beyond the width read as 1, which also provides the stop bit
    // and the idle-high fill above it.
    w_frame = {2'b11, (tx_data & w_mask) | ~w_mask, 1'b0};
`ifdef UART_MIKE_PARITY_EN
    w_frame[w_width + 4'd1] = ^(tx_data & w_mask);
    w_last  = UART_FRAME_SIZE'(w_width + 4'd2);
`else
    w_last  = UART_FRAME_SIZE'(w_width + 4'd1);
`endif
  end

  assign tx_ready = (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_index_nxt = r_index;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_busy_nxt  = r_busy;
    w_shift_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state_nxt = S_SHIFT;
          w_frame_nxt = w_frame;
          w_index_nxt = '0;
          w_last_nxt  = w_last;
          w_cnt_nxt   = baud_div;
          w_div_nxt   = baud_div;
          w_busy_nxt  = 1'b1;
          // The strobe is registered, so it must be raised one cycle
          // ahead: a zero divider makes the first cycle the last one.
          w_shift_nxt = (baud_div == '0);
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) begin
          if (r_index == r_last) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_index_nxt = r_index + 1'b1;
            w_cnt_nxt   = r_div;
            w_shift_nxt = (r_div == '0);
          end
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
          w_shift_nxt = (r_cnt == BAUD_DIV_W'(1));
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_frame_nxt = '1;
        w_index_nxt = '0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_frame_nxt = '1;
        w_index_nxt = '0;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_frame <= 11'h7FF;
      r_index <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_div   <= '0;
      r_shift <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_index <= w_index_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tx_frame = r_frame;
  assign tx_index = r_index;
  assign tx_shift = r_shift;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frame_ctrl
// Description : Self-checking bench for tx_frame_ctrl. A cycle-indexed
//               reference model derives frame contents and bit timing from
//               the frame rules; directed and randomized frames are compared
//               every cycle. Honours UART_MIKE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_ctrl;

`ifdef UART_MIKE_PARITY_EN
  localparam int c_PAR = 1;
`else
  localparam int c_PAR = 0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  uart_data_width;
  logic [15:0] baud_div;
  logic [10:0] tx_frame;
  logic [3:0]  tx_index;
  logic        tx_shift;
  logic        tx_busy;
  logic        tx_done;

  int n_checks = 0;
  int n_errors = 0;

  tx_frame_ctrl #(
    .UART_FRAME_SIZE (4),
    .BAUD_DIV_W      (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .uart_data_width (uart_data_width),
    .baud_div        (baud_div),
    .tx_frame        (tx_frame),
    .tx_index        (tx_index),
    .tx_shift        (tx_shift),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: start 0, W data bits LSB first, optional even parity,
  // everything above is 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d, input int w);
    logic [10:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int i = 0; i < w; i++) begin
      f[i+1] = d[i];
      p      = p ^ d[i];
    end
    if (c_PAR != 0) f[w+1] = p;
    return f;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
    chk({tag, "_busy"},  32'(tx_busy),  32'd0);
    chk({tag, "_frame"}, 32'(tx_frame), 32'h7FF);
    chk({tag, "_index"}, 32'(tx_index), 32'd0);
    chk({tag, "_shift"}, 32'(tx_shift), 32'd0);
    chk({tag, "_done"},  32'(tx_done),  32'd0);
  endtask

  task automatic idle_cycles(input int n);
    tx_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_idle("idle");
    end
  endtask

  // Sends one frame and checks every cycle up to and including tx_done.
  // hold keeps tx_valid high through the done cycle; rst_idx >= 0 applies an
  // asynchronous reset at the start of that bit and abandons the frame.
  task automatic run_frame(input logic [7:0] data, input logic [3:0] width,
                           input logic [15:0] div, input bit wait_neg,
                           input bit hold, input int rst_idx);
    int          w, n, per, total, idx;
    logic [10:0] ef;
    w     = (width >= 4'd5 && width <= 4'd8) ? int'(width) : 8;
    n     = w + 2 + c_PAR;
    per   = int'(div) + 1;
    total = n * per;
    ef    = exp_frame(data, w);
    if (wait_neg) @(negedge clk);
    check_idle("pre");
    tx_data         = data;
    uart_data_width = width;
    baud_div        = div;
    tx_valid        = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      // Mid-frame junk on the inputs must not matter.
      tx_valid        = hold ? 1'b1 : 1'($urandom_range(0, 1));
      tx_data         = 8'($urandom);
      uart_data_width = 4'($urandom);
      baud_div        = 16'($urandom_range(0, 7));
      idx             = (k - 1) / per;
      chk("ready", 32'(tx_ready), 32'd0);
      chk("frame", 32'(tx_frame), 32'(ef));
      if (k <= total) begin
        chk("index", 32'(tx_index), 32'(idx));
        chk("shift", 32'(tx_shift), 32'(((k - 1) % per) == per - 1));
        chk("busy",  32'(tx_busy),  32'd1);
        chk("done",  32'(tx_done),  32'd0);
      end else begin
        chk("done_pulse", 32'(tx_done),  32'd1);
        chk("done_shift", 32'(tx_shift), 32'd0);
        chk("done_index", 32'(tx_index), 32'(n - 1));
        tx_valid = hold;
      end
      if (rst_idx >= 0 && k <= total && idx == rst_idx && ((k - 1) % per) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_frame", 32'(tx_frame), 32'h7FF);
        chk("rst_index", 32'(tx_index), 32'd0);
        chk("rst_busy",  32'(tx_busy),  32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_shift", 32'(tx_shift), 32'd0);
        chk("rst_done",  32'(tx_done),  32'd0);
        tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    uart_data_width = 4'd8;
    baud_div        = 16'd0;
    #1;
    chk("reset_frame", 32'(tx_frame), 32'h7FF);
    chk("reset_index", 32'(tx_index), 32'd0);
    chk("reset_busy",  32'(tx_busy),  32'd0);
    chk("reset_shift", 32'(tx_shift), 32'd0);
    chk("reset_done",  32'(tx_done),  32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed frames.
    run_frame(8'hA5, 4'd8, 16'd3, 1'b1, 1'b0, -1);
    idle_cycles(2);
    run_frame(8'hFF, 4'd5, 16'd0, 1'b1, 1'b0, -1);
    idle_cycles(1);
    run_frame(8'h5A, 4'd3, 16'd2, 1'b1, 1'b0, -1);
    idle_cycles(1);
    run_frame(8'hC3, 4'd12, 16'd1, 1'b1, 1'b0, -1);
    idle_cycles(1);

    // Back-to-back with tx_valid held: accept in the cycle after tx_done.
    run_frame(8'h3C, 4'd8, 16'd2, 1'b1, 1'b1, -1);
    run_frame(8'h96, 4'd6, 16'd1, 1'b1, 1'b1, -1);
    run_frame(8'h0F, 4'd7, 16'd0, 1'b1, 1'b0, -1);
    idle_cycles(1);

    // Reset at bit 4, then an accept in the first cycle after release.
    run_frame(8'hA5, 4'd8, 16'd3, 1'b1, 1'b0, 4);
    run_frame(8'h11, 4'd7, 16'd1, 1'b0, 1'b0, -1);
    idle_cycles(1);

    // Randomized frames.
    for (int r = 0; r < 40; r++) begin
      run_frame(8'($urandom), 4'($urandom), 16'($urandom_range(0, 5)),
                1'b1, 1'($urandom_range(0, 1)), -1);
      if (tx_valid == 1'b0) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
